bcd_down_counter: RTL and testbench

Three-decade synchronous BCD down counter (units, tens, hundreds) with parallel load, count enable, zero flag and terminal-count pulse. It is the counting-down counterpart of the team's three-digit BCD up counter and uses the same digit-level output interface. Typical uses are countdown timers and presettable event counters.

---
 rtl/bcd_pkg.sv | 23 ++
 rtl/bcd_digit_down.sv | 38 +++
 rtl/bcd_down_counter.sv | 104 ++++++++++
 tb/tb_bcd_down_counter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD digit type, limits and per-digit helpers used by the decade
// registers and the counter top level.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

    function automatic logic bcd_invalid(input bcd_digit_t d);
        return d > BCD_MAX;
    endfunction

    // Decrement with decade wrap; the borrow itself is generated by the caller.
    function automatic bcd_digit_t bcd_dec(input bcd_digit_t d);
        return (d == BCD_MIN) ? BCD_MAX : d - 4'd1;
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One decade of a BCD down counter: loadable digit register with a
// combinational borrow to the next decade.
module bcd_digit_down
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  bcd_digit_t load_val,
    input  logic       borrow_in,
    output bcd_digit_t digit,
    output logic       borrow_out
);

    bcd_digit_t digit_q;
    bcd_digit_t digit_d;

    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = bcd_clamp(load_val);
        end else if (borrow_in) begin
            digit_d = bcd_dec(digit_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digit_q <= BCD_MIN;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit      = digit_q;
    assign borrow_out = borrow_in && (digit_q == BCD_MIN);

endmodule

// File: rtl/bcd_down_counter.sv
// Three-decade synchronous BCD down counter with parallel load, optional
// wrap at 000, zero flag, terminal-count pulse and load-error pulse.
module bcd_down_counter
    import bcd_pkg::*;
#(
    parameter bit WRAP = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_units,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_hundreds,
    input  logic       en,
    output logic [3:0] units,
    output logic [3:0] tens,
    output logic [3:0] hundreds,
    output logic       zero,
    output logic       tc,
    output logic       load_err
);

    bcd_digit_t units_cur;
    bcd_digit_t tens_cur;
    bcd_digit_t hundreds_cur;
    logic       units_borrow;
    logic       tens_borrow;
    logic       hundreds_borrow_unused;

    logic at_zero;
    logic at_one;
    logic hold;
    logic count_en;

    logic tc_q;
    logic tc_d;
    logic load_err_q;
    logic load_err_d;

    always_comb begin
        at_zero = (units_cur == BCD_MIN) && (tens_cur == BCD_MIN) && (hundreds_cur == BCD_MIN);
        at_one  = (units_cur == 4'd1) && (tens_cur == BCD_MIN) && (hundreds_cur == BCD_MIN);
    end

    // Without wrap, the whole borrow chain is starved at 000 so no decade moves.
    always_comb begin
        hold     = (WRAP == 1'b0) && at_zero;
        count_en = en && !load && !hold;
    end

    bcd_digit_down u_units (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_val   (load_units),
        .borrow_in  (count_en),
        .digit      (units_cur),
        .borrow_out (units_borrow)
    );

    bcd_digit_down u_tens (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_val   (load_tens),
        .borrow_in  (units_borrow),
        .digit      (tens_cur),
        .borrow_out (tens_borrow)
    );

    bcd_digit_down u_hundreds (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_val   (load_hundreds),
        .borrow_in  (tens_borrow),
        .digit      (hundreds_cur),
        .borrow_out (hundreds_borrow_unused)
    );

    always_comb begin
        tc_d       = count_en && at_one;
        load_err_d = load && (bcd_invalid(load_units) || bcd_invalid(load_tens)
                              || bcd_invalid(load_hundreds));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tc_q       <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            tc_q       <= tc_d;
            load_err_q <= load_err_d;
        end
    end

    assign units    = units_cur;
    assign tens     = tens_cur;
    assign hundreds = hundreds_cur;
    assign zero     = at_zero;
    assign tc       = tc_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Bench for bcd_down_counter: a wrapping and a holding instance share the
// stimulus and are compared every cycle against a decimal reference model.
module tb_bcd_down_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic       en = 1'b0;
    logic [3:0] lu = 4'd0;
    logic [3:0] lt = 4'd0;
    logic [3:0] lh = 4'd0;

    logic [3:0] u_w, t_w, h_w, u_h, t_h, h_h;
    logic       z_w, tc_w, le_w, z_h, tc_h, le_h;

    int checks = 0;
    int errors = 0;

    // Index 0 models WRAP=1, index 1 models WRAP=0.
    int m_cnt[2];
    int m_tc[2];
    int m_le[2];
    int m_tc_events[2];
    int dut_tc_events[2];

    always #5 clk = ~clk;

    bcd_down_counter #(.WRAP(1'b1)) dut_wrap (
        .clk(clk), .rst(rst), .load(load),
        .load_units(lu), .load_tens(lt), .load_hundreds(lh),
        .en(en), .units(u_w), .tens(t_w), .hundreds(h_w),
        .zero(z_w), .tc(tc_w), .load_err(le_w)
    );

    bcd_down_counter #(.WRAP(1'b0)) dut_hold (
        .clk(clk), .rst(rst), .load(load),
        .load_units(lu), .load_tens(lt), .load_hundreds(lh),
        .en(en), .units(u_h), .tens(t_h), .hundreds(h_h),
        .zero(z_h), .tc(tc_h), .load_err(le_h)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int clampi(input int d);
        return (d > 9) ? 9 : d;
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_cnt[k] = 0;
                m_tc[k]  = 0;
                m_le[k]  = 0;
            end else if (load) begin
                m_cnt[k] = clampi(int'(lh)) * 100 + clampi(int'(lt)) * 10 + clampi(int'(lu));
                m_tc[k]  = 0;
                m_le[k]  = (lh > 9 || lt > 9 || lu > 9) ? 1 : 0;
            end else if (en) begin
                m_le[k] = 0;
                if (m_cnt[k] == 0) begin
                    m_cnt[k] = (k == 0) ? 999 : 0;
                    m_tc[k]  = 0;
                end else begin
                    m_cnt[k] = m_cnt[k] - 1;
                    m_tc[k]  = (m_cnt[k] == 0) ? 1 : 0;
                    if (m_cnt[k] == 0) m_tc_events[k]++;
                end
            end else begin
                m_tc[k] = 0;
                m_le[k] = 0;
            end
        end
    endtask

    function automatic logic [31:0] expv(input int k);
        int c;
        logic [3:0] dh, dt, du;
        c  = m_cnt[k];
        dh = 4'(c / 100);
        dt = 4'((c / 10) % 10);
        du = 4'(c % 10);
        return {17'b0, dh, dt, du, (c == 0), (m_tc[k] != 0), (m_le[k] != 0)};
    endfunction

    task automatic drive(input logic r, input logic l, input logic e,
                         input logic [3:0] h, input logic [3:0] t, input logic [3:0] u);
        rst  = r;
        load = l;
        en   = e;
        lh   = h;
        lt   = t;
        lu   = u;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check({tag, "/wrap"}, {17'b0, h_w, t_w, u_w, z_w, tc_w, le_w}, expv(0));
        check({tag, "/hold"}, {17'b0, h_h, t_h, u_h, z_h, tc_h, le_h}, expv(1));
        if (tc_w) dut_tc_events[0]++;
        if (tc_h) dut_tc_events[1]++;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_tc[k] = 0; m_le[k] = 0;
            m_tc_events[k] = 0; dut_tc_events[k] = 0;
        end

        drive(1, 0, 0, 0, 0, 0);
        step("reset");
        step("reset");

        drive(0, 1, 0, 4'd1, 4'd0, 4'd0);
        step("load100");
        drive(0, 0, 1, 0, 0, 0);
        repeat (100) step("down100");
        step("past_zero");

        drive(0, 1, 0, 4'd0, 4'd0, 4'd2);
        step("load002");
        drive(0, 0, 1, 0, 0, 0);
        repeat (5) step("down002");

        drive(0, 1, 0, 4'hC, 4'd3, 4'hF);
        step("clamp");
        drive(0, 0, 0, 0, 0, 0);
        step("clamp_after");

        drive(0, 1, 0, 4'd0, 4'd5, 4'd0);
        step("load050");
        drive(0, 1, 1, 4'd7, 4'd7, 4'd7);
        step("load_and_en");
        drive(1, 1, 1, 4'hF, 4'hF, 4'hF);
        step("rst_and_load");

        for (int k = 0; k < 2; k++) begin
            m_tc_events[k]   = 0;
            dut_tc_events[k] = 0;
        end
        for (int i = 0; i < 2000; i++) begin
            logic r, l, e;
            logic [3:0] h, t, u;
            r = ($urandom % 200) == 0;
            l = ($urandom % 25) == 0;
            e = ($urandom % 10) < 7;
            if ($urandom % 2 == 0) begin
                h = 4'd0;
                t = 4'd0;
                u = 4'($urandom % 4);
            end else begin
                h = 4'($urandom % 16);
                t = 4'($urandom % 16);
                u = 4'($urandom % 16);
            end
            drive(r, l, e, h, t, u);
            step("random");
        end
        check("tc_pulses/wrap", 32'(dut_tc_events[0]), 32'(m_tc_events[0]));
        check("tc_pulses/hold", 32'(dut_tc_events[1]), 32'(m_tc_events[1]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
